// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between requesters, the arbiter and the async FIFO write side.
// master: the arbiter; slave: the requesters and FIFO around it.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_full;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_wr_data;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_full,
    output req_ready,
    output fifo_wr_en,
    output fifo_wr_data
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_full,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among N_REQ packet sources.
// Grants are held until the last flit of a packet or until MAX_BURST flits (0 = no cap).
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       wr_clk,
  input  logic                       rst_n,
  fifo_wr_arbiter_if.master          bus,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [CNT_WIDTH-1:0]       flit_cnt
);

  localparam int unsigned GntW   = $clog2(N_REQ);
  localparam int unsigned BurstW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);
  localparam logic [BurstW-1:0] BurstLast = BurstW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [GntW-1:0]     grant_q, grant_d;
  logic [GntW-1:0]     last_grant_q, last_grant_d;
  logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;

  logic                  any_valid;
  logic [GntW-1:0]       winner;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;
  logic                  burst_hit;

  // Winner is the first valid index after last_grant, wrapping modulo N_REQ.
  always_comb begin
    int unsigned idx;
    logic [GntW-1:0] idx_g;
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    idx_g     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx   = (32'(last_grant_q) + i) % N_REQ;
      idx_g = GntW'(idx);
      if (!any_valid && bus.req_valid[idx_g]) begin
        any_valid = 1'b1;
        winner    = idx_g;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (GntW'(i) == grant_q) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer      = (state_q == StBusy) && sel_valid && !bus.fifo_full;
  assign burst_hit = (MAX_BURST != 0) && (burst_cnt_q == BurstLast);

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    burst_cnt_d      = burst_cnt_q;
    flit_cnt_d       = flit_cnt_q;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = sel_data;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          grant_d     = winner;
          burst_cnt_d = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        bus.req_ready[grant_q] = !bus.fifo_full;
        bus.fifo_wr_en         = xfer;
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + BurstW'(1);
          if (flit_cnt_q != '1) begin
            flit_cnt_d = flit_cnt_q + CNT_WIDTH'(1);
          end
          if (sel_last || burst_hit) begin
            last_grant_d = grant_q;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GntW'(N_REQ - 1);
      burst_cnt_q  <= '0;
      flit_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      flit_cnt_q   <= flit_cnt_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign grant_id = grant_q;
  assign flit_cnt = flit_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: dut_a uses default parameters,
// dut_b uses MAX_BURST=4 and a 4-bit counter for the burst-cap and saturation cases.
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst_n;

  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8)) ifa ();
  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8)) ifb ();

  logic        busy_a, busy_b;
  logic [1:0]  grant_a, grant_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  fifo_wr_arbiter #(
    .N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8), .CNT_WIDTH(16)
  ) dut_a (
    .wr_clk   (clk),
    .rst_n    (rst_n),
    .bus      (ifa),
    .busy     (busy_a),
    .grant_id (grant_a),
    .flit_cnt (cnt_a)
  );

  fifo_wr_arbiter #(
    .N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(4)
  ) dut_b (
    .wr_clk   (clk),
    .rst_n    (rst_n),
    .bus      (ifb),
    .busy     (busy_b),
    .grant_id (grant_b),
    .flit_cnt (cnt_b)
  );

  localparam logic [7:0] ExpFair [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
  localparam logic [7:0] ExpLock [6] = '{8'h40, 8'hA1, 8'hA2, 8'hA3, 8'h52, 8'h50};
  localparam logic [7:0] ExpCap [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h31, 8'h32,
                                         8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
  localparam logic [7:0] ExpC [3]    = '{8'hC1, 8'hC2, 8'hC3};

  // Source model: per-requester flit stores {last, data}, popped on valid & ready.
  logic [8:0] mem_a [4][16];
  logic [8:0] mem_b [4][16];
  int head_a [4];
  int tail_a [4];
  int head_b [4];
  int tail_b [4];
  logic full_a, full_b;

  logic [7:0] wr_a [$];
  int         wc_a [$];
  logic [1:0] wg_a [$];
  logic [7:0] wr_b [$];

  int cyc;
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int which, input int src, input logic [7:0] d, input logic last);
    if (which == 0) begin
      mem_a[src][tail_a[src] % 16] = {last, d};
      tail_a[src]++;
    end else begin
      mem_b[src][tail_b[src] % 16] = {last, d};
      tail_b[src]++;
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      head_a[i] = tail_a[i];
      head_b[i] = tail_b[i];
    end
  endtask

  // Drive at the falling edge, sample 2 time units later, commit at the next rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ifa.req_valid[i]       = (head_a[i] < tail_a[i]);
      ifa.req_data[i*8 +: 8] = mem_a[i][head_a[i] % 16][7:0];
      ifa.req_last[i]        = mem_a[i][head_a[i] % 16][8];
      ifb.req_valid[i]       = (head_b[i] < tail_b[i]);
      ifb.req_data[i*8 +: 8] = mem_b[i][head_b[i] % 16][7:0];
      ifb.req_last[i]        = mem_b[i][head_b[i] % 16][8];
    end
    ifa.fifo_full = full_a;
    ifb.fifo_full = full_b;
    #2;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (ifa.req_valid[i] && ifa.req_ready[i]) head_a[i]++;
      if (ifb.req_valid[i] && ifb.req_ready[i]) head_b[i]++;
    end
    if (ifa.fifo_wr_en) begin
      wr_a.push_back(ifa.fifo_wr_data);
      wc_a.push_back(cyc);
      wg_a.push_back(grant_a);
    end
    if (ifb.fifo_wr_en) wr_b.push_back(ifb.fifo_wr_data);
  endtask

  task automatic run_until(input int which, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while ((((which == 0) ? wr_a.size() : wr_b.size()) < n) && (k < budget)) begin
      step();
      k++;
    end
    check_eq(tag, 32'((which == 0) ? wr_a.size() : wr_b.size()), 32'(n));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    full_a   = 1'b0;
    full_b   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      head_a[i] = 0; tail_a[i] = 0; head_b[i] = 0; tail_b[i] = 0;
      for (int j = 0; j < 16; j++) begin
        mem_a[i][j] = '0;
        mem_b[i][j] = '0;
      end
    end
    ifa.req_valid = '0; ifa.req_data = '0; ifa.req_last = '0; ifa.fifo_full = 1'b0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.req_last = '0; ifb.fifo_full = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(ifa.req_ready), 32'h0);
    check_eq("rst_wr_en", 32'(ifa.fifo_wr_en), 32'h0);
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    check_eq("rst_grant", 32'(grant_a), 32'h0);
    check_eq("rst_cnt", 32'(cnt_a), 32'h0);
    check_eq("rst_cnt_b", 32'(cnt_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: two single-flit packets from every requester.
    for (int i = 0; i < 4; i++) begin
      push(0, i, 8'(8'h10 + i), 1'b1);
      push(0, i, 8'(8'h20 + i), 1'b1);
    end
    run_until(0, 8, 40, "fair_count");
    step();
    for (int k = 0; k < 8; k++) begin
      check_eq("fair_data", 32'(wr_a[k]), 32'(ExpFair[k]));
      check_eq("fair_grant", 32'(wg_a[k]), 32'(k % 4));
    end
    for (int k = 1; k < 8; k++) check_eq("fair_gap", 32'(wc_a[k] - wc_a[k-1]), 32'd2);
    check_eq("fair_cnt", 32'(cnt_a), 32'd8);

    // Packet lock: req1's 3-flit packet stays contiguous; req2 follows, then req0.
    wr_a.delete(); wc_a.delete(); wg_a.delete();
    push(0, 0, 8'h40, 1'b1);
    run_until(0, 1, 10, "lock_pre");
    push(0, 0, 8'h50, 1'b1);
    push(0, 1, 8'hA1, 1'b0);
    push(0, 1, 8'hA2, 1'b0);
    push(0, 1, 8'hA3, 1'b1);
    push(0, 2, 8'h52, 1'b1);
    run_until(0, 6, 40, "lock_count");
    step();
    for (int k = 0; k < 6; k++) check_eq("lock_data", 32'(wr_a[k]), 32'(ExpLock[k]));
    check_eq("lock_gap1", 32'(wc_a[2] - wc_a[1]), 32'd1);
    check_eq("lock_gap2", 32'(wc_a[3] - wc_a[2]), 32'd1);
    check_eq("lock_grant_after", 32'(wg_a[4]), 32'd2);
    check_eq("lock_cnt", 32'(cnt_a), 32'd14);

    // Back-pressure: FIFO full for 5 cycles after the first flit of req3's packet.
    wr_a.delete(); wc_a.delete(); wg_a.delete();
    push(0, 3, 8'hC1, 1'b0);
    push(0, 3, 8'hC2, 1'b0);
    push(0, 3, 8'hC3, 1'b1);
    run_until(0, 1, 10, "bp_first");
    full_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_wr_en", 32'(ifa.fifo_wr_en), 32'h0);
      check_eq("bp_ready", 32'(ifa.req_ready), 32'h0);
      check_eq("bp_busy", 32'(busy_a), 32'h1);
      check_eq("bp_grant", 32'(grant_a), 32'd3);
      check_eq("bp_cnt", 32'(cnt_a), 32'd15);
    end
    full_a = 1'b0;
    run_until(0, 3, 20, "bp_count");
    for (int k = 0; k < 4; k++) step();
    check_eq("bp_no_dup", 32'(wr_a.size()), 32'd3);
    for (int k = 0; k < 3; k++) check_eq("bp_data", 32'(wr_a[k]), 32'(ExpC[k]));
    check_eq("bp_cnt_end", 32'(cnt_a), 32'd17);

    // Reset asserted while req0's packet is mid-transfer.
    push(0, 0, 8'hD1, 1'b0);
    push(0, 0, 8'hD2, 1'b0);
    push(0, 0, 8'hD3, 1'b1);
    step();
    step();
    check_eq("mid_busy", 32'(busy_a), 32'h1);
    check_eq("mid_wr_en", 32'(ifa.fifo_wr_en), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(ifa.req_ready), 32'h0);
    check_eq("mid_rst_wr_en", 32'(ifa.fifo_wr_en), 32'h0);
    check_eq("mid_rst_busy", 32'(busy_a), 32'h0);
    check_eq("mid_rst_cnt", 32'(cnt_a), 32'h0);
    check_eq("mid_rst_grant", 32'(grant_a), 32'h0);
    clear_sources();
    @(negedge clk);
    rst_n = 1'b1;

    // Burst cap on dut_b: req0's 10-flit packet is split around req3's packet.
    for (int k = 0; k < 10; k++) push(1, 0, 8'(k + 1), (k == 9));
    push(1, 3, 8'h31, 1'b0);
    push(1, 3, 8'h32, 1'b1);
    run_until(1, 12, 60, "cap_count");
    step();
    for (int k = 0; k < 12; k++) check_eq("cap_data", 32'(wr_b[k]), 32'(ExpCap[k]));
    check_eq("cap_cnt", 32'(cnt_b), 32'd12);

    // Saturation: 8 more writes push the 4-bit counter past 15.
    for (int k = 0; k < 8; k++) push(1, 1, 8'(8'h71 + k), 1'b1);
    run_until(1, 20, 60, "sat_count");
    step();
    check_eq("sat_last", 32'(wr_b[19]), 32'h78);
    check_eq("sat_cnt", 32'(cnt_b), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
